mem_io_ctrl: RTL and testbench

// Memory/I-O controller on the CPU's external memory port (CPU built with overrideRAM=1).

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/io_timer.sv | 104 ++++++++++
 rtl/mem_io_ctrl.sv | 117 +++++++++++
 tb/tb_mem_io_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/I-O controller: I/O page, register offsets
// and TCTRL bit positions.
package mem_io_pkg;

    localparam logic [5:0] IO_PAGE_DEF = 6'h3F;

    localparam logic [3:0] OFF_SW      = 4'h0;
    localparam logic [3:0] OFF_LED     = 4'h1;
    localparam logic [3:0] OFF_HEX     = 4'h2;
    localparam logic [3:0] OFF_BTN     = 4'h3;
    localparam logic [3:0] OFF_TCOUNT  = 4'h4;
    localparam logic [3:0] OFF_TCTRL   = 4'h5;
    localparam logic [3:0] OFF_TRELOAD = 4'h6;

    localparam int TCTRL_EN  = 0;
    localparam int TCTRL_AR  = 1;
    localparam int TCTRL_EXP = 2;

endpackage

// File: rtl/io_timer.sv
// Down-counting timer with prescaler, optional autoreload and a sticky expired
// flag that drives the interrupt line.
module io_timer
    import mem_io_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        rd_off,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam logic [15:0] PC_LAST = 16'(PRESCALE - 1);

    logic [15:0]       pc_q, pc_d;
    logic [DATA_W-1:0] tcount_q, tcount_d;
    logic [DATA_W-1:0] treload_q, treload_d;
    logic              en_q, en_d;
    logic              ar_q, ar_d;
    logic              expired_q, expired_d;
    logic              tick, expire, wr_cnt, wr_ctl, wr_rld;

    always_comb begin
        wr_cnt = wr_en && (wr_off == OFF_TCOUNT);
        wr_ctl = wr_en && (wr_off == OFF_TCTRL);
        wr_rld = wr_en && (wr_off == OFF_TRELOAD);
        tick   = en_q && (pc_q == PC_LAST);
        expire = tick && (tcount_q == '0);

        pc_d = '0;
        if (en_q && !tick)
            pc_d = pc_q + 16'd1;
        if (wr_ctl && !wdata[TCTRL_EN])
            pc_d = '0;

        tcount_d = tcount_q;
        if (tick) begin
            if (tcount_q != '0)
                tcount_d = tcount_q - 1'b1;
            else if (ar_q)
                tcount_d = treload_q;
        end
        // CPU write has priority over the tick update
        if (wr_cnt)
            tcount_d = wdata;

        treload_d = wr_rld ? wdata : treload_q;

        en_d      = en_q;
        ar_d      = ar_q;
        expired_d = expired_q;
        if (wr_ctl) begin
            en_d = wdata[TCTRL_EN];
            ar_d = wdata[TCTRL_AR];
            if (wdata[TCTRL_EXP])
                expired_d = 1'b0;
        end
        // Expiry lands after the W1C so a coincident clear cannot lose it
        if (expire) begin
            expired_d = 1'b1;
            if (!ar_q)
                en_d = 1'b0;
        end

        rdata = '0;
        case (rd_off)
            OFF_TCOUNT:  rdata = tcount_q;
            OFF_TRELOAD: rdata = treload_q;
            OFF_TCTRL: begin
                rdata[TCTRL_EN]  = en_q;
                rdata[TCTRL_AR]  = ar_q;
                rdata[TCTRL_EXP] = expired_q;
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            tcount_q  <= '0;
            treload_q <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            tcount_q  <= tcount_d;
            treload_q <= treload_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            expired_q <= expired_d;
        end
    end

    assign irq = expired_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// External-memory-port controller: splits CPU accesses between block RAM and an
// on-chip I/O page, returning read data with the RAM's single-cycle latency.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-5:0] IO_PAGE = IO_PAGE_DEF,
    parameter int              PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [9:0]        sw_in,
    input  logic [3:0]        btn_in,
    output logic [9:0]        led_out,
    output logic [DATA_W-1:0] hex_out,
    output logic              timer_irq
);

    logic [9:0]        sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [3:0]        btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [3:0]        btn_prev_q, btn_prev_d, evt_q, evt_d;
    logic [9:0]        led_q, led_d;
    logic [DATA_W-1:0] hex_q, hex_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] io_q, io_d;
    logic              io_hit, io_wr, btn_rd;
    logic [3:0]        off;
    logic [3:0]        btn_fall;
    logic [DATA_W-1:0] tmr_rdata;

    assign io_hit    = (cpu_addr[ADDR_W-1:4] == IO_PAGE);
    assign off       = cpu_addr[3:0];
    assign io_wr     = cpu_we && io_hit;
    assign btn_rd    = io_hit && !cpu_we && (off == OFF_BTN);
    assign ram_we    = cpu_we && !io_hit;
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;

    io_timer #(
        .PRESCALE (PRESCALE),
        .DATA_W   (DATA_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (io_wr),
        .wr_off (off),
        .wdata  (cpu_wdata),
        .rd_off (off),
        .rdata  (tmr_rdata),
        .irq    (timer_irq)
    );

    always_comb begin
        sw_s1_d    = sw_in;
        sw_s2_d    = sw_s1_q;
        btn_s1_d   = btn_in;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        btn_fall   = btn_prev_q & ~btn_s2_q;

        // A read clears only what it returned; a new press in the same cycle survives
        evt_d = (btn_rd ? 4'b0000 : evt_q) | btn_fall;

        led_d = (io_wr && off == OFF_LED) ? cpu_wdata[9:0] : led_q;
        hex_d = (io_wr && off == OFF_HEX) ? cpu_wdata : hex_q;

        io_d = '0;
        case (off)
            OFF_SW:  io_d = DATA_W'(sw_s2_q);
            OFF_LED: io_d = DATA_W'(led_q);
            OFF_HEX: io_d = hex_q;
            OFF_BTN: io_d = DATA_W'(evt_q);
            default: io_d = tmr_rdata;
        endcase
        sel_d = io_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '1;
            btn_s2_q   <= '1;
            btn_prev_q <= '1;
            evt_q      <= '0;
            led_q      <= '0;
            hex_q      <= '0;
            sel_q      <= 1'b0;
            io_q       <= '0;
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
            evt_q      <= evt_d;
            led_q      <= led_d;
            hex_q      <= hex_d;
            sel_q      <= sel_d;
            io_q       <= io_d;
        end
    end

    assign cpu_rdata = sel_q ? io_q : ram_rdata;
    assign led_out   = led_q;
    assign hex_out   = hex_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: reads push expected words, a monitor pops
// and compares one cycle later; register-output checks are done inline.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [9:0]  sw_in = '0;
    logic [3:0]  btn_in = 4'hF;
    logic [9:0]  led_out;
    logic [15:0] hex_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    logic        tb_rd = 1'b0;
    logic        rd_seen = 1'b0;
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic [15:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_io_ctrl #(.PRESCALE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .btn_in    (btn_in),
        .led_out   (led_out),
        .hex_out   (hex_out),
        .timer_irq (timer_irq)
    );

    // Registered-read block RAM model
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    always @(posedge clk) rd_seen <= tb_rd & reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 16'h0001, 16'h0000);
            end else begin
                chk(name_q.pop_front(), cpu_rdata, exp_q.pop_front());
            end
        end
        if (cpu_we && reset)
            chk("ram_we_decode", {15'b0, ram_we}, {15'b0, (cpu_addr[9:4] != 6'h3F)});
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tb_rd     = 1'b0;
        cyc();
        cpu_we    = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [15:0] e, input string name);
        cpu_addr = a;
        cpu_we   = 1'b0;
        tb_rd    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(name);
        cyc();
        tb_rd    = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_led", {6'b0, led_out}, 16'h0000);
        chk("rst_hex", hex_out, 16'h0000);
        chk("rst_irq", {15'b0, timer_irq}, 16'h0000);
        chk("rst_rdata_is_ram", cpu_rdata, ram_rdata);
        reset = 1'b1;
        cyc();

        wr(10'h3F2, 16'h1234);
        wr(10'h3F1, 16'h03FF);
        chk("hex_out", hex_out, 16'h1234);
        chk("led_out", {6'b0, led_out}, 16'h03FF);
        wr(10'h3F1, 16'hFC0F);
        rd(10'h3F1, 16'h000F, "led_narrow");

        wr(10'h010, 16'hBEEF);
        rd(10'h010, 16'hBEEF, "ram_read");
        rd(10'h3F2, 16'h1234, "hex_read_b2b");
        wr(10'h3F9, 16'hFFFF);
        rd(10'h3F9, 16'h0000, "unused_off");
        wr(10'h3F0, 16'hFFFF);

        sw_in = 10'h2A5;
        cyc(3);
        rd(10'h3F0, 16'h02A5, "sw_read");

        btn_in = 4'b1011;
        cyc(4);
        rd(10'h3F3, 16'h0004, "btn_evt");
        rd(10'h3F3, 16'h0000, "btn_evt_cleared");
        btn_in = 4'hF;
        cyc(4);
        btn_in = 4'b1110;
        cyc(2);
        rd(10'h3F3, 16'h0000, "btn_read_same_cycle");
        rd(10'h3F3, 16'h0001, "btn_set_wins");
        rd(10'h3F3, 16'h0000, "btn_reclear");
        btn_in = 4'hF;

        // Timer, PRESCALE = 4: expiry 12 edges after enabling
        wr(10'h3F6, 16'h0002);
        wr(10'h3F4, 16'h0002);
        wr(10'h3F5, 16'h0003);
        cyc(11);
        chk("irq_not_yet", {15'b0, timer_irq}, 16'h0000);
        cyc();
        chk("irq_set", {15'b0, timer_irq}, 16'h0001);
        rd(10'h3F4, 16'h0002, "tcount_reload");
        rd(10'h3F5, 16'h0007, "tctrl_expired");
        wr(10'h3F5, 16'h0007);
        chk("irq_w1c", {15'b0, timer_irq}, 16'h0000);
        rd(10'h3F5, 16'h0003, "tctrl_en_kept");
        cyc(7);
        wr(10'h3F5, 16'h0007);
        chk("expiry_beats_w1c", {15'b0, timer_irq}, 16'h0001);
        cyc(3);
        wr(10'h3F4, 16'h0009);
        rd(10'h3F4, 16'h0009, "write_beats_tick");

        wr(10'h3F5, 16'h0004);
        chk("irq_cleared", {15'b0, timer_irq}, 16'h0000);
        wr(10'h3F4, 16'h0000);
        wr(10'h3F5, 16'h0001);
        cyc(3);
        chk("oneshot_not_yet", {15'b0, timer_irq}, 16'h0000);
        cyc();
        chk("oneshot_irq", {15'b0, timer_irq}, 16'h0001);
        rd(10'h3F5, 16'h0004, "oneshot_en_off");
        rd(10'h3F4, 16'h0000, "oneshot_tcount");

        // Reset with an I/O read in flight
        wr(10'h020, 16'h5A5A);
        wr(10'h3F4, 16'h0005);
        wr(10'h3F5, 16'h0003);
        cyc(2);
        cpu_addr = 10'h3F2;
        cyc();
        reset    = 1'b0;
        cpu_addr = 10'h020;
        #1;
        chk("mid_rst_led", {6'b0, led_out}, 16'h0000);
        chk("mid_rst_hex", hex_out, 16'h0000);
        chk("mid_rst_irq", {15'b0, timer_irq}, 16'h0000);
        cyc();
        chk("mid_rst_rdata", cpu_rdata, 16'h5A5A);
        reset = 1'b1;
        cyc();
        rd(10'h3F4, 16'h0000, "post_rst_tcount");
        rd(10'h3F5, 16'h0000, "post_rst_tctrl");
        rd(10'h3F3, 16'h0000, "post_rst_evt");
        cyc(2);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
